// File: rtl/bthreadgroup_psum_collector_if.sv
// bthreadgroup_psum_collector_if: step, partial-sum feedback and output-FIFO signals of the psum collector
interface bthreadgroup_psum_collector_if #(parameter int CNT_W = 8);
   logic               start;
   logic [CNT_W-1:0]   num_steps;
   logic               res_valid;
   logic               step_ready;
   logic signed [15:0] result0, result1, result2, result3;
   logic signed [15:0] partial_sum0, partial_sum1, partial_sum2, partial_sum3;
   logic               out_valid;
   logic               out_ready;
   logic [63:0]        out_data;
   logic               busy;
   logic               done;
   logic               drop_err;
   modport master (
      output start, num_steps, res_valid, result0, result1, result2, result3, out_ready,
      input  step_ready, partial_sum0, partial_sum1, partial_sum2, partial_sum3,
             out_valid, out_data, busy, done, drop_err
   );
   modport slave (
      input  start, num_steps, res_valid, result0, result1, result2, result3, out_ready,
      output step_ready, partial_sum0, partial_sum1, partial_sum2, partial_sum3,
             out_valid, out_data, busy, done, drop_err
   );
endinterface

// File: rtl/bthreadgroup_psum_collector.sv
// bthreadgroup_psum_collector: closes the FEDP K-loop and queues finished 4x16b sums in an output FIFO
module bthreadgroup_psum_collector #(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 8
) (
   input logic clk,
   input logic rst,
   bthreadgroup_psum_collector_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic {IDLE, ACCUM} state_t;
   state_t             state;
   logic signed [15:0] acc0, acc1, acc2, acc3;
   logic [CNT_W-1:0]   cnt, nsteps;
   logic [63:0]        mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic [AW:0]        count;
   logic               done_q, drop_q;
   logic               full, empty, accept, last, push, pop, begin_tile;
   assign full       = count == (AW+1)'(FIFO_DEPTH);
   assign empty      = count == '0;
   assign bus.step_ready = (state == ACCUM) && !full;
   assign accept     = bus.res_valid && bus.step_ready;
   assign last       = cnt == nsteps - CNT_W'(1);
   assign push       = accept && last;
   assign pop        = !empty && bus.out_ready;
   assign begin_tile = (state == IDLE) && bus.start && (bus.num_steps != '0);
   assign bus.partial_sum0 = acc0;
   assign bus.partial_sum1 = acc1;
   assign bus.partial_sum2 = acc2;
   assign bus.partial_sum3 = acc3;
   assign bus.out_valid    = !empty;
   assign bus.out_data     = mem[rd_ptr];
   assign bus.busy         = state != IDLE;
   assign bus.done         = done_q;
   assign bus.drop_err     = drop_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc0   <= '0;
         acc1   <= '0;
         acc2   <= '0;
         acc3   <= '0;
         cnt    <= '0;
         nsteps <= '0;
         done_q <= 1'b0;
         drop_q <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         done_q <= 1'b0;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (begin_tile) begin
            state  <= ACCUM;
            nsteps <= bus.num_steps;
            cnt    <= '0;
            acc0   <= '0;
            acc1   <= '0;
            acc2   <= '0;
            acc3   <= '0;
            drop_q <= 1'b0;
         end else if (accept && last) begin
            state  <= IDLE;
            cnt    <= '0;
            acc0   <= '0;
            acc1   <= '0;
            acc2   <= '0;
            acc3   <= '0;
            done_q <= 1'b1;
         end else if (accept) begin
            cnt  <= cnt + CNT_W'(1);
            acc0 <= bus.result0;
            acc1 <= bus.result1;
            acc2 <= bus.result2;
            acc3 <= bus.result3;
         end
         if (bus.res_valid && !bus.step_ready) drop_q <= 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.result3, bus.result2, bus.result1, bus.result0};
   end
endmodule

// File: tb/tb_bthreadgroup_psum_collector.sv
// tb_bthreadgroup_psum_collector: directed checks of the psum collector with immediate assertions
module tb_bthreadgroup_psum_collector;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   always #5 clk = ~clk;
   bthreadgroup_psum_collector_if #(.CNT_W(8)) bus ();
   bthreadgroup_psum_collector #(.FIFO_DEPTH(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic tile1(input logic [15:0] v);
      bus.start = 1'b1;
      bus.num_steps = 8'd1;
      tick();
      bus.start = 1'b0;
      bus.res_valid = 1'b1;
      bus.result0 = v;
      tick();
      bus.res_valid = 1'b0;
   endtask
   initial begin
      bus.start = 1'b0;
      bus.num_steps = '0;
      bus.res_valid = 1'b0;
      bus.result0 = '0;
      bus.result1 = '0;
      bus.result2 = '0;
      bus.result3 = '0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_step_ready", bus.step_ready, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_drop_err", bus.drop_err, 0);
      chk("rst_psum0", bus.partial_sum0, 0);
      rst = 1'b0;
      tick();
      // three-step tile on lane0
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      bus.num_steps = 8'd3;
      tick();
      bus.start = 1'b0;
      chk("t2_busy", bus.busy, 1);
      chk("t2_step_ready", bus.step_ready, 1);
      chk("t2_psum_a", bus.partial_sum0, 0);
      bus.res_valid = 1'b1;
      bus.result0 = 16'd5;
      tick();
      chk("t2_psum_b", bus.partial_sum0, 5);
      bus.result0 = 16'd12;
      tick();
      chk("t2_psum_c", bus.partial_sum0, 12);
      bus.result0 = 16'd30;
      tick();
      bus.res_valid = 1'b0;
      chk("t2_out_valid", bus.out_valid, 1);
      chk("t2_out_data", bus.out_data[15:0], 30);
      chk("t2_done", bus.done, 1);
      chk("t2_busy_fall", bus.busy, 0);
      chk("t2_psum_clr", bus.partial_sum0, 0);
      tick();
      chk("t2_done_pulse", bus.done, 0);
      chk("t2_popped", bus.out_valid, 0);
      // zero-step start ignored; start while busy ignored
      bus.start = 1'b1;
      bus.num_steps = 8'd0;
      tick();
      bus.start = 1'b0;
      chk("t5_zero_busy", bus.busy, 0);
      tick();
      chk("t5_zero_done", bus.done, 0);
      bus.start = 1'b1;
      bus.num_steps = 8'd2;
      tick();
      chk("t5_busy", bus.busy, 1);
      bus.num_steps = 8'd5;
      bus.res_valid = 1'b1;
      bus.result0 = 16'd7;
      tick();
      chk("t5_psum", bus.partial_sum0, 7);
      bus.start = 1'b0;
      bus.result0 = 16'd9;
      tick();
      bus.res_valid = 1'b0;
      chk("t5_done", bus.done, 1);
      chk("t5_data", bus.out_data[15:0], 9);
      chk("t5_idle", bus.busy, 0);
      bus.result0 = '0;
      tick();
      // signed wrap on lane3
      bus.start = 1'b1;
      bus.num_steps = 8'd2;
      tick();
      bus.start = 1'b0;
      bus.res_valid = 1'b1;
      bus.result3 = 16'h7FFF;
      tick();
      chk("t6_psum3", bus.partial_sum3, 16'h7FFF);
      bus.result3 = 16'h8000;
      tick();
      bus.res_valid = 1'b0;
      chk("t6_lane3", bus.out_data[63:48], 16'h8000);
      chk("t6_lane0", bus.out_data[15:0], 0);
      bus.result3 = '0;
      tick();
      // fill FIFO with out_ready low, then a dropped beat
      bus.out_ready = 1'b0;
      for (int k = 0; k < 4; k++) tile1(16'(101 + k));
      chk("t3_head", bus.out_data[15:0], 101);
      bus.start = 1'b1;
      bus.num_steps = 8'd1;
      tick();
      bus.start = 1'b0;
      chk("t3_full_ready", bus.step_ready, 0);
      chk("t3_busy", bus.busy, 1);
      bus.res_valid = 1'b1;
      bus.result0 = 16'd999;
      tick();
      bus.res_valid = 1'b0;
      chk("t3_drop_err", bus.drop_err, 1);
      chk("t3_acc_kept", bus.partial_sum0, 0);
      chk("t3_still_busy", bus.busy, 1);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("t3_drain", bus.out_data[15:0], 64'(101 + k));
         tick();
      end
      chk("t3_empty", bus.out_valid, 0);
      chk("t3_ready_back", bus.step_ready, 1);
      bus.res_valid = 1'b1;
      bus.result0 = 16'd105;
      tick();
      bus.res_valid = 1'b0;
      chk("t3_tile5", bus.out_data[15:0], 105);
      chk("t3_sticky", bus.drop_err, 1);
      tick();
      chk("t3_empty2", bus.out_valid, 0);
      // push and pop together with one entry held, across pointer wrap
      bus.out_ready = 1'b0;
      tile1(16'd200);
      chk("t4_drop_clr", bus.drop_err, 0);
      for (int k = 1; k <= 7; k++) begin
         bus.start = 1'b1;
         bus.num_steps = 8'd1;
         tick();
         bus.start = 1'b0;
         chk("t4_head_before", bus.out_data[15:0], 64'(199 + k));
         bus.res_valid = 1'b1;
         bus.result0 = 16'(200 + k);
         bus.out_ready = 1'b1;
         tick();
         bus.res_valid = 1'b0;
         bus.out_ready = 1'b0;
         chk("t4_valid", bus.out_valid, 1);
         chk("t4_head_after", bus.out_data[15:0], 64'(200 + k));
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("t4_one_left", bus.out_valid, 0);
      // reset mid-tile with two queued words
      tile1(16'd300);
      tile1(16'd301);
      chk("t1_queued", bus.out_valid, 1);
      bus.start = 1'b1;
      bus.num_steps = 8'd3;
      tick();
      bus.start = 1'b0;
      bus.res_valid = 1'b1;
      bus.result0 = 16'd55;
      tick();
      bus.res_valid = 1'b0;
      chk("t1_psum_pre", bus.partial_sum0, 55);
      rst = 1'b1;
      #1;
      chk("t1_rst_out_valid", bus.out_valid, 0);
      chk("t1_rst_busy", bus.busy, 0);
      chk("t1_rst_psum", bus.partial_sum0, 0);
      chk("t1_rst_ready", bus.step_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("t1_post_out_valid", bus.out_valid, 0);
      chk("t1_post_busy", bus.busy, 0);
      chk("t1_post_psum", bus.partial_sum0, 0);
      chk("t1_post_done", bus.done, 0);
      tile1(16'd400);
      chk("t1_fresh_head", bus.out_data[15:0], 400);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
